issue_req_gen: RTL and testbench
================================

Name: issue_req_gen

Overview:
- Requester side of the issue select tree: owns per-entry request state for one issue-queue partition.
- Drives leaf request vectors into the select tree and consumes the returned grant vector.
- Encodes the grant into a registered issue index and releases entries back to the freelist.
- Sits between dispatch/wakeup logic and the select tree leaves.

Parameters:
- NUM_ENTRIES, 16, issue-queue entries tracked; must be a power of two, at least 2.
- IDX_W, 4, entry index width; equals log2(NUM_ENTRIES).
- REPLAY_WINDOW, 2, cycles an issued entry is held before it is freed (used only with the optional feature); range 1..7.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- alloc_valid_i  in  1  dispatch writes entry alloc_idx_i this cycle.
- alloc_idx_i  in  IDX_W  entry being allocated.
- alloc_ready_i  in  1  operands of the allocated entry are already ready.
- wakeup_i  in  NUM_ENTRIES  per-entry operand-ready pulses.
- flush_i  in  1  squash: all entries return to FREE.
- grant_i  in  NUM_ENTRIES  grant vector from the select tree; one-hot or zero.
- req_o  out  NUM_ENTRIES  request vector to the select tree leaves.
- issue_valid_o  out  1  registered: an entry was granted last cycle.
- issue_idx_o  out  IDX_W  registered index of the granted entry.
- free_o  out  NUM_ENTRIES  registered one-cycle pulses for entries returned to FREE.
- occupancy_o  out  IDX_W+1  registered count of non-FREE entries.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low. While reset is low, all entries are FREE and every output is 0.
- Entry states: FREE, WAIT, REQ, ISSUED (ISSUED exists only with the optional feature).
- FREE -> WAIT on alloc when alloc_ready_i=0 and the entry's wakeup bit is 0.
- FREE -> REQ on alloc when alloc_ready_i=1 or the entry's wakeup bit is 1 in the same cycle.
- WAIT -> REQ on the wakeup bit. Wakeup on FREE, REQ or ISSUED is ignored.
- req_o[i] = (state[i]==REQ), decoded from registers only. There is no combinational path from grant_i to req_o.
- Grant handling: only the lowest set bit of grant_i is honoured.
- If the granted entry is in REQ: it leaves REQ at the next edge, issue_valid_o=1 and issue_idx_o=index in the following cycle, so latency is 1 cycle.
- If the granted entry is not in REQ: no state change, err_o is set.
- If more than one grant bit is set: err_o is set and the lowest bit is still honoured.
- Without the optional feature, a granted entry goes REQ -> FREE, and free_o[i] pulses for 1 cycle in the cycle after.
- Alloc to a non-FREE entry is ignored and sets err_o.
- flush_i has priority over alloc, wakeup and grant. At the next edge all entries are FREE, issue_valid_o=0, occupancy_o=0, and free_o is not pulsed (the freelist resets itself on flush).
- occupancy_o updates every cycle. At most one alloc and one free occur per cycle, so the count changes by at most 1, and alloc plus free in the same cycle leaves it unchanged.
- err_o clears only on reset.
- Reset asserted mid-operation clears all state immediately; no pending issue or free is emitted afterwards.

Optional Feature:
- Macro: ISSUE_REQ_REPLAY_EN.
- Enabled: adds ports replay_valid_i (1) and replay_idx_i (IDX_W).
  - A granted entry goes REQ -> ISSUED and loads a 3-bit counter with REPLAY_WINDOW.
  - The counter decrements each cycle; when it reaches 0 the entry goes to FREE and free_o pulses the next cycle.
  - replay_valid_i on an ISSUED entry returns it to REQ. Replay beats expiry in the same cycle.
  - Replay to a non-ISSUED entry sets err_o.
  - Flush clears ISSUED entries as well.
- Disabled: the ports and counters do not exist, and grant frees the entry directly as above.

Decomposition:
- Shared package issue_sel_pkg holds: the entry-state enum (FREE=2'b00, WAIT=2'b01, REQ=2'b10, ISSUED=2'b11), the default NUM_ENTRIES/IDX_W constants, and the replay counter width (3).
- One sub-module, grant_encoder: combinational; lowest-set-bit one-hot to index plus a valid bit and a multi-hot flag. It is instantiated once and its outputs are registered in issue_req_gen.

Test Plan:
- Alloc idx 3 with alloc_ready_i=1; grant_i=16'h0008 next cycle -> req_o[3]=1 one cycle after alloc; issue_valid_o=1, issue_idx_o=3 one cycle after grant; free_o=16'h0008 the following cycle (feature off).
- Alloc idx 5 with ready=0, wakeup_i[5] two cycles later -> req_o[5] stays 0 until the cycle after the wakeup, then 1; occupancy_o=1 throughout.
- grant_i=16'h0030 with entries 4 and 5 both in REQ -> only entry 4 issues (issue_idx_o=4), err_o=1, req_o[5] stays 1.
- Entries 1, 2, 7 allocated, flush_i together with alloc idx 9 -> next cycle req_o=0, occupancy_o=0, free_o=0, entry 9 not allocated.
- ISSUE_REQ_REPLAY_EN, REPLAY_WINDOW=2: grant entry 6, replay_valid_i idx 6 one cycle later -> entry 6 back in REQ, no free_o pulse. Without the replay, free_o[6] pulses 3 cycles after the grant edge.
- Reset dropped asynchronously mid-cycle while issue_valid_o=1 -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/issue_sel_pkg.sv
// -----------------------------------------------------------------------------
// issue_sel_pkg
// Shared definitions for the issue select tree requester side.
//   entry_state_t   : per-entry issue-queue state encoding
//   DEF_NUM_ENTRIES : default number of tracked issue-queue entries
//   DEF_IDX_W       : default entry index width (log2 of DEF_NUM_ENTRIES)
//   REPLAY_CNT_W    : width of the per-entry replay hold counter
// -----------------------------------------------------------------------------
package issue_sel_pkg;

  typedef enum logic [1:0] {
    ST_FREE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_REQ    = 2'b10,
    ST_ISSUED = 2'b11
  } entry_state_t;

  localparam int DEF_NUM_ENTRIES = 16;
  localparam int DEF_IDX_W       = 4;
  localparam int REPLAY_CNT_W    = 3;

endpackage

// File: rtl/issue_req_gen_grant_encoder.sv
// -----------------------------------------------------------------------------
// grant_encoder
// Purely combinational grant decoder for the select tree return path.
// Honours only the lowest set bit of the grant vector.
// Ports:
//   grant : grant vector from the select tree (expected one-hot or zero)
//   idx   : index of the lowest set grant bit (0 when no bit is set)
//   valid : at least one grant bit is set
//   multi : more than one grant bit is set (protocol violation)
// -----------------------------------------------------------------------------
module grant_encoder #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic [NUM_ENTRIES-1:0] grant,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid,
  output logic                   multi
);

  logic found;

  // Scan upward and stop at the first hit so the lowest bit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (grant[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  assign valid = |grant;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(grant & (grant - 1'b1));

endmodule

// File: rtl/issue_req_gen.sv
// -----------------------------------------------------------------------------
// issue_req_gen
// Requester side of the issue select tree for one issue-queue partition.
// Tracks per-entry request state, drives leaf requests, consumes grants,
// registers the issued index and returns entries to the freelist.
//
// Optional feature macro: ISSUE_REQ_REPLAY_EN
//   When defined, granted entries park in ISSUED for REPLAY_WINDOW cycles and
//   may be sent back to REQ by replay_valid_i/replay_idx_i before they free.
//
// Ports:
//   clk, reset        : clock; asynchronous active-low reset
//   alloc_valid_i/idx : dispatch allocates entry alloc_idx_i
//   alloc_ready_i     : allocated entry's operands are already ready
//   wakeup_i          : per-entry operand-ready pulses
//   flush_i           : squash every entry back to FREE
//   grant_i           : select tree grant vector (one-hot or zero)
//   replay_valid_i/idx: (feature only) return an ISSUED entry to REQ
//   req_o             : request vector to the select tree leaves
//   issue_valid_o/idx : registered issue of the entry granted last cycle
//   free_o            : registered one-cycle pulses of entries freed
//   occupancy_o       : registered count of non-FREE entries
//   err_o             : sticky protocol-error flag
//
// Handshake: a grant is accepted only for an entry whose req_o bit is set in
// the same cycle; the entry drops its request at that edge and issue_valid_o
// reports it during the following cycle. There is no backpressure.
// -----------------------------------------------------------------------------
module issue_req_gen
  import issue_sel_pkg::*;
#(
  parameter int NUM_ENTRIES   = DEF_NUM_ENTRIES,
  parameter int IDX_W         = DEF_IDX_W,
  parameter int REPLAY_WINDOW = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc_valid_i,
  input  logic [IDX_W-1:0]       alloc_idx_i,
  input  logic                   alloc_ready_i,
  input  logic [NUM_ENTRIES-1:0] wakeup_i,
  input  logic                   flush_i,
  input  logic [NUM_ENTRIES-1:0] grant_i,
`ifdef ISSUE_REQ_REPLAY_EN
  input  logic                   replay_valid_i,
  input  logic [IDX_W-1:0]       replay_idx_i,
`endif
  output logic [NUM_ENTRIES-1:0] req_o,
  output logic                   issue_valid_o,
  output logic [IDX_W-1:0]       issue_idx_o,
  output logic [NUM_ENTRIES-1:0] free_o,
  output logic [IDX_W:0]         occupancy_o,
  output logic                   err_o
);

  // Elaboration-time parameter sanity.
  if (NUM_ENTRIES != (1 << IDX_W) || NUM_ENTRIES < 2) begin : g_bad_entries
    $error("issue_req_gen: NUM_ENTRIES must equal 2**IDX_W and be >= 2");
  end
  if (REPLAY_WINDOW < 1 || REPLAY_WINDOW > 7) begin : g_bad_window
    $error("issue_req_gen: REPLAY_WINDOW must be in 1..7");
  end

  entry_state_t st_q [NUM_ENTRIES];
  entry_state_t st_d [NUM_ENTRIES];

  // Grant accepted at edge N is staged here, then pulses on free_o after N+1.
  logic [NUM_ENTRIES-1:0] free_pend_q;
  logic [NUM_ENTRIES-1:0] free_pend_d;
  logic                   issue_valid_d;
  logic [IDX_W-1:0]       issue_idx_d;
  logic                   err_d;
  logic [IDX_W:0]         occ_d;

`ifdef ISSUE_REQ_REPLAY_EN
  logic [REPLAY_CNT_W-1:0] cnt_q [NUM_ENTRIES];
  logic [REPLAY_CNT_W-1:0] cnt_d [NUM_ENTRIES];
`endif

  logic [IDX_W-1:0] g_idx;
  logic             g_valid;
  logic             g_multi;

  grant_encoder #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_grant_encoder (
    .grant (grant_i),
    .idx   (g_idx),
    .valid (g_valid),
    .multi (g_multi)
  );

  // Requests come straight from state registers; grant_i never reaches req_o.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      req_o[i] = (st_q[i] == ST_REQ);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      st_d[i] = st_q[i];
`ifdef ISSUE_REQ_REPLAY_EN
      cnt_d[i] = cnt_q[i];
`endif
    end
    free_pend_d   = '0;
    issue_valid_d = 1'b0;
    issue_idx_d   = '0;
    err_d         = err_o;
    occ_d         = '0;

    if (flush_i) begin
      // Flush wins over everything; the freelist resets itself, so no pulses.
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        st_d[i] = ST_FREE;
`ifdef ISSUE_REQ_REPLAY_EN
        cnt_d[i] = '0;
`endif
      end
    end else begin
      // Wakeup and replay/expiry only touch WAIT and ISSUED entries, so they
      // never collide with grant (REQ) or alloc (FREE) updates below.
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (st_q[i] == ST_WAIT && wakeup_i[i]) begin
          st_d[i] = ST_REQ;
        end
`ifdef ISSUE_REQ_REPLAY_EN
        if (st_q[i] == ST_ISSUED) begin
          if (replay_valid_i && replay_idx_i == IDX_W'(i)) begin
            st_d[i] = ST_REQ;          // replay beats expiry
          end else if (cnt_q[i] == REPLAY_CNT_W'(1)) begin
            st_d[i]        = ST_FREE;  // counter reaches 0 at this edge
            cnt_d[i]       = '0;
            free_pend_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
`endif
      end

`ifdef ISSUE_REQ_REPLAY_EN
      if (replay_valid_i && st_q[replay_idx_i] != ST_ISSUED) begin
        err_d = 1'b1;
      end
`endif

      if (g_valid) begin
        if (st_q[g_idx] == ST_REQ) begin
          issue_valid_d = 1'b1;
          issue_idx_d   = g_idx;
`ifdef ISSUE_REQ_REPLAY_EN
          st_d[g_idx]  = ST_ISSUED;
          cnt_d[g_idx] = REPLAY_CNT_W'(REPLAY_WINDOW);
`else
          st_d[g_idx]        = ST_FREE;
          free_pend_d[g_idx] = 1'b1;
`endif
        end else begin
          err_d = 1'b1;
        end
        if (g_multi) begin
          err_d = 1'b1;
        end
      end

      if (alloc_valid_i) begin
        if (st_q[alloc_idx_i] == ST_FREE) begin
          st_d[alloc_idx_i] = (alloc_ready_i || wakeup_i[alloc_idx_i]) ? ST_REQ : ST_WAIT;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    // Count straight from next state so occupancy always matches the entries.
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (st_d[i] != ST_FREE) begin
        occ_d = occ_d + {{IDX_W{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        st_q[i] <= ST_FREE;
`ifdef ISSUE_REQ_REPLAY_EN
        cnt_q[i] <= '0;
`endif
      end
      free_pend_q   <= '0;
      free_o        <= '0;
      issue_valid_o <= 1'b0;
      issue_idx_o   <= '0;
      occupancy_o   <= '0;
      err_o         <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        st_q[i] <= st_d[i];
`ifdef ISSUE_REQ_REPLAY_EN
        cnt_q[i] <= cnt_d[i];
`endif
      end
      free_pend_q   <= free_pend_d;
      free_o        <= flush_i ? '0 : free_pend_q;
      issue_valid_o <= issue_valid_d;
      issue_idx_o   <= issue_idx_d;
      occupancy_o   <= occ_d;
      err_o         <= err_d;
    end
  end

endmodule

// File: tb/tb_issue_req_gen.sv
// -----------------------------------------------------------------------------
// tb_issue_req_gen
// Directed bench for issue_req_gen with hand-computed expectations.
// An issue-index scoreboard queue is filled when a grant is expected to be
// accepted and drained by a negedge monitor on issue_valid_o.
// -----------------------------------------------------------------------------
module tb_issue_req_gen;

  localparam int N  = 16;
  localparam int IW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          alloc_valid;
  logic [IW-1:0] alloc_idx;
  logic          alloc_ready;
  logic [N-1:0]  wakeup;
  logic          flush;
  logic [N-1:0]  grant;
`ifdef ISSUE_REQ_REPLAY_EN
  logic          replay_valid;
  logic [IW-1:0] replay_idx;
`endif
  logic [N-1:0]  req;
  logic          issue_valid;
  logic [IW-1:0] issue_idx;
  logic [N-1:0]  free;
  logic [IW:0]   occupancy;
  logic          err;

  issue_req_gen #(
    .NUM_ENTRIES   (N),
    .IDX_W         (IW),
    .REPLAY_WINDOW (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .alloc_valid_i (alloc_valid),
    .alloc_idx_i   (alloc_idx),
    .alloc_ready_i (alloc_ready),
    .wakeup_i      (wakeup),
    .flush_i       (flush),
    .grant_i       (grant),
`ifdef ISSUE_REQ_REPLAY_EN
    .replay_valid_i(replay_valid),
    .replay_idx_i  (replay_idx),
`endif
    .req_o         (req),
    .issue_valid_o (issue_valid),
    .issue_idx_o   (issue_idx),
    .free_o        (free),
    .occupancy_o   (occupancy),
    .err_o         (err)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [IW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && issue_valid === 1'b1) begin
      if (exp_q.size() == 0) check("issue_unexpected", 32'(issue_idx), 32'hFFFF_FFFF);
      else check("issue_idx_sb", 32'(issue_idx), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    alloc_idx   = '0;
    alloc_ready = 1'b0;
    wakeup      = '0;
    flush       = 1'b0;
    grant       = '0;
`ifdef ISSUE_REQ_REPLAY_EN
    replay_valid = 1'b0;
    replay_idx   = '0;
`endif
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic alloc(input logic [IW-1:0] idx, input logic rdy);
    alloc_valid = 1'b1;
    alloc_idx   = idx;
    alloc_ready = rdy;
    tick();
    alloc_valid = 1'b0;
    alloc_ready = 1'b0;
  endtask

  // Watchdog: every wait is tick-bounded, this only guards a stuck clock.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle();
    #1 reset = 1'b0;
    #2;
    check("rst_req",  32'(req), 32'h0);
    check("rst_iv",   32'(issue_valid), 32'h0);
    check("rst_free", 32'(free), 32'h0);
    check("rst_occ",  32'(occupancy), 32'h0);
    check("rst_err",  32'(err), 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // 1: ready alloc, grant, issue, free
    alloc(4'd3, 1'b1);
    check("t1_req",  32'(req), 32'h0008);
    check("t1_occ",  32'(occupancy), 32'h1);
    grant = 16'h0008;
    exp_q.push_back(4'd3);
    tick();
    grant = '0;
    check("t1_iv",    32'(issue_valid), 32'h1);
    check("t1_idx",   32'(issue_idx), 32'h3);
    check("t1_free0", 32'(free), 32'h0);
    check("t1_req0",  32'(req), 32'h0);
    check("t1_occ0",  32'(occupancy), 32'h0);
    tick();
    check("t1_free",  32'(free), 32'h0008);
    check("t1_iv0",   32'(issue_valid), 32'h0);
    tick();
    check("t1_free_end", 32'(free), 32'h0);
    check("t1_err",   32'(err), 32'h0);

    // 2: wait state, wakeup two cycles later, then alloc into busy entry
    do_reset();
    alloc(4'd5, 1'b0);
    check("t2_req_a", 32'(req), 32'h0);
    check("t2_occ_a", 32'(occupancy), 32'h1);
    tick();
    wakeup = 16'h0020;
    check("t2_req_b", 32'(req), 32'h0);
    tick();
    wakeup = '0;
    check("t2_req_c", 32'(req), 32'h0020);
    check("t2_occ_c", 32'(occupancy), 32'h1);
    alloc(4'd5, 1'b1);
    check("t2_busy_err", 32'(err), 32'h1);
    check("t2_busy_occ", 32'(occupancy), 32'h1);

    // 3: multi-hot grant honours the lowest bit
    do_reset();
    alloc(4'd4, 1'b1);
    alloc(4'd5, 1'b1);
    check("t3_req", 32'(req), 32'h0030);
    check("t3_occ", 32'(occupancy), 32'h2);
    grant = 16'h0030;
    exp_q.push_back(4'd4);
    tick();
    grant = '0;
    check("t3_iv",   32'(issue_valid), 32'h1);
    check("t3_idx",  32'(issue_idx), 32'h4);
    check("t3_err",  32'(err), 32'h1);
    check("t3_req2", 32'(req), 32'h0020);
    check("t3_occ2", 32'(occupancy), 32'h1);

    // 4: grant to a FREE entry
    do_reset();
    grant = 16'h0001;
    tick();
    grant = '0;
    check("t4_iv",  32'(issue_valid), 32'h0);
    check("t4_err", 32'(err), 32'h1);
    check("t4_occ", 32'(occupancy), 32'h0);

    // 5: flush beats alloc, grant and pending free
    do_reset();
    alloc(4'd1, 1'b1);
    alloc(4'd2, 1'b1);
    alloc(4'd7, 1'b1);
    check("t5_req", 32'(req), 32'h0086);
    check("t5_occ", 32'(occupancy), 32'h3);
    flush = 1'b1;
    alloc(4'd9, 1'b1);
    flush = 1'b0;
    check("t5_req_f",  32'(req), 32'h0);
    check("t5_occ_f",  32'(occupancy), 32'h0);
    check("t5_free_f", 32'(free), 32'h0);
    check("t5_err_f",  32'(err), 32'h0);
    tick();
    check("t5_no9", 32'(req), 32'h0);
    alloc(4'd2, 1'b1);
    grant = 16'h0004;
    flush = 1'b1;
    tick();
    grant = '0;
    flush = 1'b0;
    check("t5_iv_flush", 32'(issue_valid), 32'h0);
    check("t5_occ_g",    32'(occupancy), 32'h0);
    alloc(4'd2, 1'b1);
    grant = 16'h0004;
    exp_q.push_back(4'd2);
    tick();
    grant = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_free_sup", 32'(free), 32'h0);
    check("t5_iv_sup",   32'(issue_valid), 32'h0);
    tick();
    check("t5_free_sup2", 32'(free), 32'h0);

    // 6: alloc and free in the same cycle keep occupancy steady
    do_reset();
    alloc(4'd3, 1'b1);
    grant = 16'h0008;
    exp_q.push_back(4'd3);
    alloc(4'd8, 1'b0);
    grant = '0;
    check("t6_occ", 32'(occupancy), 32'h1);
    check("t6_req", 32'(req), 32'h0);
    tick();
    check("t6_free", 32'(free), 32'h0008);
    check("t6_occ2", 32'(occupancy), 32'h1);

`ifdef ISSUE_REQ_REPLAY_EN
    // 7: replay returns to REQ; without replay, free after window
    do_reset();
    alloc(4'd6, 1'b1);
    grant = 16'h0040;
    exp_q.push_back(4'd6);
    tick();
    grant = '0;
    check("t7_iv",  32'(issue_valid), 32'h1);
    check("t7_occ", 32'(occupancy), 32'h1);
    check("t7_req", 32'(req), 32'h0);
    replay_valid = 1'b1;
    replay_idx   = 4'd6;
    tick();
    replay_valid = 1'b0;
    check("t7_rep_req", 32'(req), 32'h0040);
    repeat (3) begin
      tick();
      check("t7_rep_nofree", 32'(free), 32'h0);
    end
    grant = 16'h0040;
    exp_q.push_back(4'd6);
    tick();
    grant = '0;
    tick();
    check("t7_free_e1", 32'(free), 32'h0);
    tick();
    check("t7_free_e2", 32'(free), 32'h0);
    check("t7_occ_e2",  32'(occupancy), 32'h0);
    tick();
    check("t7_free_e3", 32'(free), 32'h0040);
    check("t7_err0",    32'(err), 32'h0);
    replay_valid = 1'b1;
    replay_idx   = 4'd6;
    tick();
    replay_valid = 1'b0;
    check("t7_rep_err", 32'(err), 32'h1);
`endif

    // 8: asynchronous reset mid-cycle with an issue in flight
    do_reset();
    alloc(4'd6, 1'b1);
    alloc(4'd6, 1'b1);
    grant = 16'h0040;
    exp_q.push_back(4'd6);
    tick();
    grant = '0;
    check("t8_iv_pre",  32'(issue_valid), 32'h1);
    check("t8_err_pre", 32'(err), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("t8_iv",   32'(issue_valid), 32'h0);
    check("t8_idx",  32'(issue_idx), 32'h0);
    check("t8_free", 32'(free), 32'h0);
    check("t8_occ",  32'(occupancy), 32'h0);
    check("t8_err",  32'(err), 32'h0);
    check("t8_req",  32'(req), 32'h0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("t8_no_free", 32'(free), 32'h0);
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
